// File: rtl/mfb_frame_checker_if.sv
// MFB monitored bus: data, framing and handshake of one MFB stream.
interface mfb_frame_checker_if #(
    parameter int unsigned REGIONS     = 4,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8
);
    localparam int unsigned DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int unsigned SOF_POS_W = REGIONS * $clog2(REGION_SIZE);
    localparam int unsigned EOF_POS_W = REGIONS * $clog2(REGION_SIZE * BLOCK_SIZE);

    logic [DATA_W-1:0]    data;
    logic [REGIONS-1:0]   sof;
    logic [REGIONS-1:0]   eof;
    logic [SOF_POS_W-1:0] sof_pos;
    logic [EOF_POS_W-1:0] eof_pos;
    logic                 src_rdy;
    logic                 dst_rdy;

    modport master (output data, sof, eof, sof_pos, eof_pos, src_rdy, dst_rdy);
    modport slave  (input  data, sof, eof, sof_pos, eof_pos, src_rdy, dst_rdy);
endinterface

// File: rtl/mfb_frame_checker.sv
// Passive MFB frame checker: SOF/EOF sequencing, position, stall-hold and
// optional length checks with sticky flags, counters and first-error capture.
// Optional frame length check enabled by defining MFB_FRAME_CHECKER_LEN_EN.
module mfb_frame_checker #(
    parameter int unsigned REGIONS     = 4,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8,
`ifdef MFB_FRAME_CHECKER_LEN_EN
    parameter int unsigned MTU         = 16383,
    parameter int unsigned MIN_LEN     = 60,
`endif
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    mfb_frame_checker_if.slave           mfb,
    output logic [4:0]                   err_flags_o,
    output logic                         err_valid_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    output logic [CNT_WIDTH-1:0]         frame_cnt_o,
    output logic [4:0]                   first_err_code_o,
    output logic [$clog2(REGIONS)-1:0]   first_err_region_o,
    output logic                         in_frame_o
);
    localparam int unsigned SP_W   = $clog2(REGION_SIZE);
    localparam int unsigned EP_W   = $clog2(REGION_SIZE * BLOCK_SIZE);
    localparam int unsigned RI     = REGION_SIZE * BLOCK_SIZE;
    localparam int unsigned DATA_W = REGIONS * RI * ITEM_WIDTH;
    localparam int unsigned RG_W   = $clog2(REGIONS);
    localparam int unsigned FC_W   = $clog2(REGIONS + 1);
    localparam int unsigned CS_W   = CNT_WIDTH + 1;
`ifdef MFB_FRAME_CHECKER_LEN_EN
    localparam int unsigned LEN_W  = $clog2(MTU + 2) + 1;
`endif

    logic                   f_q, f_d;
    logic                   stall_q;
    logic [DATA_W-1:0]      data_q;
    logic [REGIONS-1:0]     sof_q, eof_q;
    logic [REGIONS*SP_W-1:0] sof_pos_q;
    logic [REGIONS*EP_W-1:0] eof_pos_q;
    logic [4:0]             err_flags_q, err_flags_d;
    logic                   err_valid_q;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [4:0]             first_code_q, first_code_d;
    logic [RG_W-1:0]        first_region_q, first_region_d;

    logic                   xfer;
    logic                   hold_err;
    logic [4:0]             err_vec;
    logic [RG_W-1:0]        err_region;
    logic [FC_W-1:0]        frames;
    logic [4:0]             region_err;
    logic                   found, close, sof, eof;
    logic [SP_W-1:0]        spos;
    logic [EP_W-1:0]        epos, s_item;
    logic [4:0]             base_flags;
    logic [CS_W-1:0]        err_sum, frame_sum;
`ifdef MFB_FRAME_CHECKER_LEN_EN
    logic [LEN_W-1:0]       len_q, len_d, close_len, len_sum;
`endif

    assign xfer = mfb.src_rdy & mfb.dst_rdy;

    // A stalled word must be presented again unchanged on the next cycle.
    assign hold_err = stall_q & (~mfb.src_rdy | (mfb.data != data_q) | (mfb.sof != sof_q) |
                                 (mfb.eof != eof_q) | (mfb.sof_pos != sof_pos_q) |
                                 (mfb.eof_pos != eof_pos_q));

    // Walk regions in order, carrying frame state and length through the word.
    always_comb begin
        f_d        = f_q;
        err_vec    = '0;
        err_region = '0;
        frames     = '0;
        found      = 1'b0;
        region_err = '0;
        close      = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        spos       = '0;
        epos       = '0;
        s_item     = '0;
`ifdef MFB_FRAME_CHECKER_LEN_EN
        len_d      = len_q;
        close_len  = '0;
        len_sum    = '0;
`endif
        if (xfer) begin
            for (int r = 0; r < int'(REGIONS); r++) begin
                region_err = '0;
                close      = 1'b0;
                sof        = mfb.sof[r];
                eof        = mfb.eof[r];
                spos       = mfb.sof_pos[r*SP_W +: SP_W];
                epos       = mfb.eof_pos[r*EP_W +: EP_W];
                s_item     = EP_W'(spos) * EP_W'(BLOCK_SIZE);
`ifdef MFB_FRAME_CHECKER_LEN_EN
                close_len  = '0;
`endif
                case ({sof, eof})
                    2'b10: begin
                        region_err[0] = f_d;
                        f_d = 1'b1;
`ifdef MFB_FRAME_CHECKER_LEN_EN
                        len_d = LEN_W'(RI) - LEN_W'(s_item);
`endif
                    end
                    2'b01: begin
                        if (f_d) begin
                            close = 1'b1;
                            f_d   = 1'b0;
`ifdef MFB_FRAME_CHECKER_LEN_EN
                            close_len = len_d + LEN_W'(epos) + LEN_W'(1);
`endif
                        end else begin
                            region_err[1] = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (!f_d) begin
                            if (epos >= s_item) begin
                                close = 1'b1;
`ifdef MFB_FRAME_CHECKER_LEN_EN
                                close_len = LEN_W'(epos - s_item) + LEN_W'(1);
`endif
                            end else begin
                                region_err[2] = 1'b1;
                            end
                        end else if (epos < s_item) begin
                            close = 1'b1;
`ifdef MFB_FRAME_CHECKER_LEN_EN
                            close_len = len_d + LEN_W'(epos) + LEN_W'(1);
                            len_d     = LEN_W'(RI) - LEN_W'(s_item);
`endif
                        end else begin
                            region_err[0] = 1'b1;
                            f_d = 1'b0;
                        end
                    end
                    default: begin
`ifdef MFB_FRAME_CHECKER_LEN_EN
                        if (f_d) begin
                            len_sum = len_d + LEN_W'(RI);
                            len_d   = (len_sum > LEN_W'(MTU + 1)) ? LEN_W'(MTU + 1) : len_sum;
                        end
`endif
                    end
                endcase
`ifdef MFB_FRAME_CHECKER_LEN_EN
                if (close && ((close_len > LEN_W'(MTU)) || (close_len < LEN_W'(MIN_LEN))))
                    region_err[4] = 1'b1;
`endif
                if (close && (region_err == '0))
                    frames = frames + FC_W'(1);
                if ((region_err != '0) && !found) begin
                    found      = 1'b1;
                    err_region = RG_W'(r);
                end
                err_vec = err_vec | region_err;
            end
        end
        if (hold_err) begin
            err_vec[3] = 1'b1;
            err_region = '0;
        end
    end

    // Status update: clear restarts from zero but still records this cycle.
    always_comb begin
        base_flags     = clr_i ? 5'd0 : err_flags_q;
        err_flags_d    = base_flags | err_vec;
        err_sum        = {1'b0, (clr_i ? '0 : err_cnt_q)} + CS_W'(|err_vec);
        frame_sum      = {1'b0, (clr_i ? '0 : frame_cnt_q)} + CS_W'(frames);
        err_cnt_d      = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        frame_cnt_d    = frame_sum[CNT_WIDTH] ? '1 : frame_sum[CNT_WIDTH-1:0];
        first_code_d   = clr_i ? 5'd0 : first_code_q;
        first_region_d = clr_i ? '0 : first_region_q;
        if ((base_flags == 5'd0) && (err_vec != 5'd0)) begin
            first_code_d   = err_vec;
            first_region_d = err_region;
        end
    end

    // Frame state, stall marker and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q            <= 1'b0;
            stall_q        <= 1'b0;
            err_flags_q    <= '0;
            err_valid_q    <= 1'b0;
            err_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            first_code_q   <= '0;
            first_region_q <= '0;
`ifdef MFB_FRAME_CHECKER_LEN_EN
            len_q          <= '0;
`endif
        end else begin
            f_q            <= f_d;
            stall_q        <= mfb.src_rdy & ~mfb.dst_rdy;
            err_flags_q    <= err_flags_d;
            err_valid_q    <= |err_vec;
            err_cnt_q      <= err_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            first_code_q   <= first_code_d;
            first_region_q <= first_region_d;
`ifdef MFB_FRAME_CHECKER_LEN_EN
            len_q          <= len_d;
`endif
        end
    end

    // Snapshot of the presented word for the stall-hold comparison.
    always_ff @(posedge clk) begin
        data_q    <= mfb.data;
        sof_q     <= mfb.sof;
        eof_q     <= mfb.eof;
        sof_pos_q <= mfb.sof_pos;
        eof_pos_q <= mfb.eof_pos;
    end

    assign err_flags_o        = err_flags_q;
    assign err_valid_o        = err_valid_q;
    assign err_cnt_o          = err_cnt_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign first_err_code_o   = first_code_q;
    assign first_err_region_o = first_region_q;
    assign in_frame_o         = f_q;
endmodule

// File: tb/tb_mfb_frame_checker.sv
// Bench for mfb_frame_checker: frame-list stream model plus directed error cases.
module tb_mfb_frame_checker;
    localparam int MTU     = 16383;
    localparam int MIN_LEN = 60;
    localparam int RI      = 64;
    localparam int MAXR    = 1024;
`ifdef MFB_FRAME_CHECKER_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  err_flags, first_code;
    logic        err_valid, in_frame;
    logic [31:0] err_cnt, frame_cnt;
    logic [1:0]  first_region;

    mfb_frame_checker_if bus ();

    mfb_frame_checker dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clr_i              (clr),
        .mfb                (bus),
        .err_flags_o        (err_flags),
        .err_valid_o        (err_valid),
        .err_cnt_o          (err_cnt),
        .frame_cnt_o        (frame_cnt),
        .first_err_code_o   (first_code),
        .first_err_region_o (first_region),
        .in_frame_o         (in_frame)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream model: frames placed on an item line, projected onto regions.
    bit ev_sof[MAXR];
    bit ev_eof[MAXR];
    int ev_spos[MAXR];
    int ev_epos[MAXR];
    int n_regions, exp_frames, exp_errcyc;
    bit exp_len_err;
    int frame_lens[$];

    task automatic build_stream(input int max_gap);
        int cursor, start, fin, rs, re, ps, pe, last_bad;
        for (int i = 0; i < MAXR; i++) begin
            ev_sof[i] = 0; ev_eof[i] = 0; ev_spos[i] = 0; ev_epos[i] = 0;
        end
        cursor = 0; ps = -1; pe = -1; last_bad = -1;
        exp_frames = 0; exp_errcyc = 0; exp_len_err = 0; n_regions = 0;
        foreach (frame_lens[k]) begin
            start = ((cursor + 7) / 8) * 8 + 8 * $urandom_range(0, max_gap);
            rs = start / RI;
            if (rs == pe && (rs == ps || (start + frame_lens[k] - 1) / RI == rs))
                start = (rs + 1) * RI;
            rs  = start / RI;
            fin = start + frame_lens[k] - 1;
            re  = fin / RI;
            if (re >= MAXR) begin
                $display("FAIL build: stream exceeds %0d regions", MAXR);
                $fatal(1);
            end
            ev_sof[rs] = 1; ev_spos[rs] = (start % RI) / 8;
            ev_eof[re] = 1; ev_epos[re] = fin % RI;
            if (LEN_EN && (frame_lens[k] < MIN_LEN || frame_lens[k] > MTU)) begin
                exp_len_err = 1;
                if (re / 4 != last_bad) begin
                    exp_errcyc++;
                    last_bad = re / 4;
                end
            end else begin
                exp_frames++;
            end
            cursor = fin + 1; ps = rs; pe = re; n_regions = re + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src_rdy = 0; bus.dst_rdy = 0; bus.sof = '0; bus.eof = '0;
        bus.sof_pos = '0; bus.eof_pos = '0; clr = 0;
        step();
    endtask

    task automatic rand_data();
        for (int i = 0; i < 64; i++) bus.data[i*32 +: 32] = $urandom;
    endtask

    task automatic put_word(input int w);
        int gr;
        rand_data();
        for (int r = 0; r < 4; r++) begin
            gr = w * 4 + r;
            bus.sof[r] = ev_sof[gr];
            bus.eof[r] = ev_eof[gr];
            bus.sof_pos[r*3 +: 3] = 3'(ev_spos[gr]);
            bus.eof_pos[r*6 +: 6] = 6'(ev_epos[gr]);
        end
    endtask

    // Present each word until accepted; random idles and bounded stalls.
    task automatic send_stream();
        int tries;
        bit acc;
        for (int w = 0; w < (n_regions + 3) / 4; w++) begin
            if ($urandom_range(0, 3) == 0) idle();
            put_word(w);
            tries = 0;
            do begin
                bus.src_rdy = 1;
                bus.dst_rdy = (tries >= 6) || ($urandom_range(0, 2) != 0);
                acc = bus.dst_rdy;
                step();
                tries++;
            end while (!acc);
        end
        idle();
    endtask

    task automatic expect_stream(input string p);
        check({p, ".frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        check({p, ".flags"}, 64'(err_flags), exp_len_err ? 64'h10 : 64'h0);
        check({p, ".err_cnt"}, 64'(err_cnt), 64'(exp_errcyc));
        check({p, ".in_frame"}, 64'(in_frame), 64'h0);
    endtask

    task automatic drive_word(input logic [3:0] sof, input logic [3:0] eof,
                              input logic [11:0] spos, input logic [23:0] epos);
        rand_data();
        bus.sof = sof; bus.eof = eof; bus.sof_pos = spos; bus.eof_pos = epos;
        bus.src_rdy = 1; bus.dst_rdy = 1;
        step();
    endtask

    task automatic pulse_clr();
        bus.src_rdy = 0; bus.dst_rdy = 0; bus.sof = '0; bus.eof = '0;
        clr = 1;
        step();
        clr = 0;
    endtask

    task automatic check_zero(input string p);
        check({p, ".flags"}, 64'(err_flags), 64'h0);
        check({p, ".valid"}, 64'(err_valid), 64'h0);
        check({p, ".err_cnt"}, 64'(err_cnt), 64'h0);
        check({p, ".frame_cnt"}, 64'(frame_cnt), 64'h0);
        check({p, ".first_code"}, 64'(first_code), 64'h0);
        check({p, ".first_region"}, 64'(first_region), 64'h0);
        check({p, ".in_frame"}, 64'(in_frame), 64'h0);
    endtask

    logic [3:0]  hold_sof;

    initial begin
        bus.data = '0;
        idle();
        check_zero("reset");
        rst_n = 1;
        idle();

        // Three legal frames with random stalls
        frame_lens = '{64, 65, 1500};
        build_stream(0);
        send_stream();
        expect_stream("three_frames");

        // Random legal-position traffic, mixed lengths
        pulse_clr();
        check("clr.frame_cnt", 64'(frame_cnt), 64'h0);
        frame_lens = {};
        for (int i = 0; i < 25; i++) frame_lens.push_back($urandom_range(50, 1600));
        build_stream(3);
        send_stream();
        expect_stream("random");

        // SOF in region 1 while region 0 opened a frame
        pulse_clr();
        drive_word(4'b0011, 4'b0000, 12'h0, 24'h0);
        check("sof_in_frame.flags", 64'(err_flags), 64'h01);
        check("sof_in_frame.region", 64'(first_region), 64'h1);
        check("sof_in_frame.code", 64'(first_code), 64'h01);
        check("sof_in_frame.err_cnt", 64'(err_cnt), 64'h1);
        check("sof_in_frame.valid", 64'(err_valid), 64'h1);
        check("sof_in_frame.in_frame", 64'(in_frame), 64'h1);
        idle();
        check("sof_in_frame.valid_drop", 64'(err_valid), 64'h0);
        drive_word(4'b0000, 4'b0001, 12'h0, 24'd63);
        check("resync_close.frame_cnt", 64'(frame_cnt), 64'h1);
        check("resync_close.err_cnt", 64'(err_cnt), 64'h1);
        idle();

        // EOF before SOF inside one region
        pulse_clr();
        drive_word(4'b0001, 4'b0001, 12'd4, 24'd10);
        check("pos_order.flags", 64'(err_flags), 64'h04);
        check("pos_order.frame_cnt", 64'(frame_cnt), 64'h0);
        check("pos_order.region", 64'(first_region), 64'h0);
        check("pos_order.in_frame", 64'(in_frame), 64'h0);
        idle();

        // Stall held correctly, then data changes under the stall
        pulse_clr();
        rand_data();
        hold_sof = 4'($urandom_range(0, 15)) & 4'b0000;
        bus.sof = hold_sof; bus.eof = '0; bus.src_rdy = 1; bus.dst_rdy = 0;
        step();
        step();
        check("hold_ok.flags", 64'(err_flags), 64'h0);
        bus.data[0] = ~bus.data[0];
        bus.dst_rdy = 1;
        step();
        check("hold.flags", 64'(err_flags), 64'h08);
        check("hold.region", 64'(first_region), 64'h0);
        check("hold.err_cnt", 64'(err_cnt), 64'h1);
        idle();

        // Short and oversized frames
        pulse_clr();
        frame_lens = '{59, 16384};
        build_stream(0);
        send_stream();
        expect_stream("length");

        // Clear coincident with an EOF outside a frame
        clr = 1;
        drive_word(4'b0000, 4'b0001, 12'h0, 24'd63);
        clr = 0;
        check("clr_err.flags", 64'(err_flags), 64'h02);
        check("clr_err.err_cnt", 64'(err_cnt), 64'h1);
        check("clr_err.code", 64'(first_code), 64'h02);
        check("clr_err.frame_cnt", 64'(frame_cnt), 64'h0);
        check("clr_err.valid", 64'(err_valid), 64'h1);

        // Reset with a frame open, then a lone EOF
        drive_word(4'b0001, 4'b0000, 12'h0, 24'h0);
        check("open.in_frame", 64'(in_frame), 64'h1);
        rst_n = 0;
        #2;
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1;
        drive_word(4'b0000, 4'b0001, 12'h0, 24'd20);
        check("post_reset.flags", 64'(err_flags), 64'h02);
        check("post_reset.in_frame", 64'(in_frame), 64'h0);
        check("post_reset.frame_cnt", 64'(frame_cnt), 64'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
